// File: rtl/cell_draw_arbiter.sv
// Round-robin arbiter that shares the VGA pixel-write port among NREQ drawing clients,
// sweeping one CELL_W x CELL_H board cell per grant and colouring it from the client's select code.
module cell_draw_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned CELL_W = 12,
  parameter int unsigned CELL_H = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] x_in,
  input  logic [NREQ*7-1:0] y_in,
  input  logic [NREQ*2-1:0] sel_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int unsigned   PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_RST = PW'(NREQ - 1);
  localparam logic [3:0]    CX_MAX   = 4'(CELL_W - 1);
  localparam logic [3:0]    CY_MAX   = 4'(CELL_H - 1);
  localparam logic [2:0]    C_GREEN  = 3'b010;
  localparam logic [2:0]    C_BLACK  = 3'b000;
  localparam logic [2:0]    C_WHITE  = 3'b111;
  localparam logic [2:0]    C_RED    = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [7:0]        x0_q, x0_d;
  logic [6:0]        y0_q, y0_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        cx_q, cx_d;
  logic [3:0]        cy_q, cy_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic              border;
  logic              pix_plot;
  logic [2:0]        pix_col;

  // Round-robin pick: first requester after the last winner
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= int'(NREQ); off++) begin
      cand = PW'((int'(last_q) + off) % int'(NREQ));
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Per-pixel colour and write strobe from the latched select code
  always_comb begin
    border = (cx_q == 4'd0) || (cx_q == CX_MAX) || (cy_q == 4'd0) || (cy_q == CY_MAX);
    pix_plot = 1'b1;
    pix_col  = C_GREEN;
    case (sel_q)
      2'b00:   pix_col = C_GREEN;
      2'b01:   pix_col = border ? C_GREEN : C_BLACK;
      2'b10:   pix_col = border ? C_GREEN : C_WHITE;
      default: begin
        pix_plot = border;
        pix_col  = C_RED;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    sel_d    = sel_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    grant_d  = grant_q;
    done_d   = '0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = NREQ'(1) << win_idx;
          last_d  = win_idx;
          gidx_d  = win_idx;
          x0_d    = x_in[int'(win_idx)*8 +: 8];
          y0_d    = y_in[int'(win_idx)*7 +: 7];
          sel_d   = sel_in[int'(win_idx)*2 +: 2];
          cx_d    = 4'd0;
          cy_d    = 4'd0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        plot_d = pix_plot;
        if (pix_plot) begin
          x_d      = x0_q + 8'(cx_q);
          y_d      = y0_q + 7'(cy_q);
          colour_d = pix_col;
        end
        if (cx_q == CX_MAX) begin
          cx_d = 4'd0;
          if (cy_q == CY_MAX) begin
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        done_d  = NREQ'(1) << gidx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= LAST_RST;
      gidx_q   <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      sel_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      sel_q    <= sel_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_cell_draw_arbiter.sv
// Scoreboard bench for cell_draw_arbiter: a cycle-counted reference model queues expected
// pixels and done pulses; a negedge monitor pops and compares them against the DUT.
module tb_cell_draw_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 12;
  localparam int H    = 12;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] x_in;
  logic [NREQ*7-1:0] y_in;
  logic [NREQ*2-1:0] sel_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;

  cell_draw_arbiter #(.NREQ(NREQ), .CELL_W(W), .CELL_H(H)) dut (
    .clock(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .sel_in(sel_in),
    .grant(grant), .done(done), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] d;
  } dn_t;

  pix_t pq[$];
  dn_t  dq[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitrates from sampled req using cycle arithmetic only
  int              cyc = 0;
  int              m_last = NREQ - 1;
  int              m_free = 0;
  int              m_end = 0;
  logic [NREQ-1:0] m_grant = '0;
  bit              rst_seen = 1'b0;
  int              m_g;
  logic [7:0]      m_x0;
  logic [6:0]      m_y0;
  logic [1:0]      m_s;
  logic [2:0]      m_c;
  bit              m_b;
  pix_t            m_p;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_last   = NREQ - 1;
      m_free   = 0;
      m_grant  = '0;
      rst_seen = 1'b1;
      pq.delete();
      dq.delete();
    end else begin
      if (m_grant != 0 && cyc == m_end) m_grant = '0;
      if (cyc >= m_free && req != 0) begin
        m_g = -1;
        for (int off = 1; off <= NREQ; off++)
          if (m_g < 0 && req[(m_last + off) % NREQ]) m_g = (m_last + off) % NREQ;
        m_last  = m_g;
        m_grant = NREQ'(1) << m_g;
        m_end   = cyc + W * H + 1;
        m_free  = cyc + W * H + 2;
        m_x0    = x_in[8*m_g +: 8];
        m_y0    = y_in[7*m_g +: 7];
        m_s     = sel_in[2*m_g +: 2];
        for (int yy = 0; yy < H; yy++) begin
          for (int xx = 0; xx < W; xx++) begin
            m_b = (xx == 0) || (xx == W - 1) || (yy == 0) || (yy == H - 1);
            case (m_s)
              2'd0:    m_c = 3'b010;
              2'd1:    m_c = m_b ? 3'b010 : 3'b000;
              2'd2:    m_c = m_b ? 3'b010 : 3'b111;
              default: m_c = 3'b100;
            endcase
            if (m_s != 2'd3 || m_b) begin
              m_p.cyc = cyc + 1 + yy * W + xx;
              m_p.px  = m_x0 + 8'(xx);
              m_p.py  = m_y0 + 7'(yy);
              m_p.pc  = m_c;
              pq.push_back(m_p);
            end
          end
        end
        dq.push_back('{cyc: cyc + W * H + 1, d: NREQ'(1) << m_g});
      end
    end
  end

  // Monitor: compares DUT outputs against queued expectations away from the active edge
  pix_t            mp;
  bit              exp_plot;
  logic [NREQ-1:0] exp_done;
  bit              dn_hit;

  always @(negedge clk) begin
    if (rst_seen) begin
      rst_seen = 1'b0;
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_colour", 32'(colour), 32'd0);
    end
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_grant != 0));
    exp_plot = (pq.size() > 0) && (pq[0].cyc == cyc);
    chk("plot", 32'(plot), 32'(exp_plot));
    if (exp_plot) begin
      mp = pq.pop_front();
      if (plot) begin
        chk("pix_x", 32'(x), 32'(mp.px));
        chk("pix_y", 32'(y), 32'(mp.py));
        chk("pix_colour", 32'(colour), 32'(mp.pc));
      end
    end
    dn_hit   = (dq.size() > 0) && (dq[0].cyc == cyc);
    exp_done = dn_hit ? dq[0].d : '0;
    chk("done", 32'(done), 32'(exp_done));
    if (dn_hit) void'(dq.pop_front());
  end

  task automatic set_client(input int i, input logic [7:0] xv, input logic [6:0] yv,
                            input logic [1:0] sv);
    x_in[8*i +: 8]   = xv;
    y_in[7*i +: 7]   = yv;
    sel_in[2*i +: 2] = sv;
  endtask

  task automatic rand_client(input int i);
    set_client(i, 8'($urandom), 7'($urandom), 2'($urandom));
  endtask

  task automatic wait_done(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (done[i]) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL timeout_done%0d: no done pulse within 2000 cycles", i);
    end
  endtask

  task automatic wait_grant(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (grant[i]) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL timeout_grant%0d: no grant within 2000 cycles", i);
    end
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    x_in   = '0;
    y_in   = '0;
    sel_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single black-disk cell, then a cell that wraps both axes
    set_client(0, 8'd32, 7'd12, 2'b01);
    req = 3'b001;
    wait_done(0);
    req = 3'b000;
    @(negedge clk);
    set_client(0, 8'd250, 7'd124, 2'b00);
    req = 3'b001;
    wait_done(0);
    req = 3'b000;
    @(negedge clk);

    // All clients held: round-robin, client 1 draws a cursor
    set_client(0, 8'd0, 7'd0, 2'b10);
    set_client(1, 8'd60, 7'd40, 2'b11);
    set_client(2, 8'd100, 7'd90, 2'b01);
    req = 3'b111;
    repeat (4) begin
      bit got = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
        @(negedge clk);
        if (done != 0) got = 1'b1;
      end
      nvec++;
      if (!got) begin
        nerr++;
        $display("FAIL timeout_rr: no done pulse within 2000 cycles");
      end
    end
    req = 3'b000;
    @(negedge clk);

    // Reset in the middle of a client-2 sweep, then 0 and 2 compete
    req = 3'b100;
    wait_grant(2);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b101;
    wait_done(0);
    req[0] = 1'b0;
    wait_done(2);
    req[2] = 1'b0;
    @(negedge clk);

    // Request dropped mid-sweep still completes the cell
    req = 3'b001;
    wait_grant(0);
    repeat (12) @(negedge clk);
    req = 3'b000;
    wait_done(0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 9000; n++) begin
      @(negedge clk);
      reset = ($urandom % 3000 == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && ($urandom % 4 != 0)) req[i] = 1'b0;
        else if (!req[i] && ($urandom % 16 == 0)) begin
          rand_client(i);
          req[i] = 1'b1;
        end else if (req[i] && ($urandom % 500 == 0)) req[i] = 1'b0;
        else if ($urandom % 50 == 0) rand_client(i);
      end
    end
    reset = 1'b0;
    req   = '0;

    begin
      bit idle = 1'b0;
      for (int n = 0; n < 400 && !idle; n++) begin
        @(negedge clk);
        if (!busy && pq.size() == 0 && dq.size() == 0) idle = 1'b1;
      end
      nvec++;
      if (!idle) begin
        nerr++;
        $display("FAIL drain: busy=%0d pixels_left=%0d dones_left=%0d", busy, pq.size(), dq.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
